fetch_queue: RTL and testbench

- Instruction fetch buffer sitting directly downstream of the instruction cache response path and upstream of the dual-issue decode stage.
- Accepts up to two 32-bit instructions per cycle: the 64-bit cache data word plus the PC of slot 0.
- Holds them in a circular buffer and presents the two oldest entries to decode, which may consume 0, 1 or 2 per cycle.
- Decouples cache hit/miss timing from decode stalls; flushable on redirect (branch mispredict, exception, ERET).

---
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the I-cache response and dual-issue decode.
// Circular buffer of {pc, inst}; accepts up to two slots per cycle and presents the two oldest.
module fetch_queue #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [1:0]          in_mask,
    input  logic [31:0]         in_pc,
    input  logic [63:0]         in_data,
    output logic                in_ready,
    output logic [1:0]          out_valid,
    output logic [31:0]         out_inst0,
    output logic [31:0]         out_pc0,
    output logic [31:0]         out_inst1,
    output logic [31:0]         out_pc1,
    input  logic [1:0]          out_accept,
    output logic [PTR_BITS:0]   count
);

    typedef logic [PTR_BITS:0]   cnt_t;
    typedef logic [PTR_BITS-1:0] ptr_t;

    localparam cnt_t DepthCnt = cnt_t'(DEPTH);
    localparam cnt_t RoomMax  = cnt_t'(DEPTH - 2);

    logic [31:0] pc_q   [DEPTH];
    logic [31:0] inst_q [DEPTH];

    ptr_t head_q, head_d, tail_q, tail_d;
    ptr_t head_p1, tail_p1;
    cnt_t count_q, count_d;

    logic       push;
    logic [1:0] npush, npop, acc;

    assign head_p1 = head_q + ptr_t'(1);
    assign tail_p1 = tail_q + ptr_t'(1);

    // Admission looks only at registered occupancy; same-cycle pops never free space.
    assign in_ready  = resetn && (count_q <= RoomMax);
    assign out_valid = resetn ? {count_q > cnt_t'(1), count_q != '0} : 2'b00;

    assign out_pc0   = pc_q[head_q];
    assign out_inst0 = inst_q[head_q];
    assign out_pc1   = pc_q[head_p1];
    assign out_inst1 = inst_q[head_p1];
    assign count     = count_q;

    assign push  = in_valid & in_ready & ~flush;
    assign npush = {1'b0, in_mask[0]} + {1'b0, in_mask[1]};
    assign acc   = out_accept & out_valid;
    assign npop  = flush ? 2'd0 : ({1'b0, acc[0]} + {1'b0, acc[1]});

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + ptr_t'(npop);
            tail_d  = tail_q + (push ? ptr_t'(npush) : ptr_t'(0));
            count_d = count_q + (push ? cnt_t'(npush) : cnt_t'(0)) - cnt_t'(npop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_q]   <= in_pc;
            inst_q[tail_q] <= in_data[31:0];
            if (in_mask[1]) begin
                pc_q[tail_p1]   <= in_pc + 32'd4;
                inst_q[tail_p1] <= in_data[63:32];
            end
        end
    end

    assert property (@(posedge clk) disable iff (!resetn)
        (count_q == {1'b0, tail_q - head_q}) || (count_q == DepthCnt && tail_q == head_q));
    assert property (@(posedge clk) disable iff (!resetn) count_q <= DepthCnt);
    assert property (@(posedge clk) disable iff (!resetn) cnt_t'(npop) <= count_q);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: driver queues expected visible state per cycle,
// a negedge monitor pops and compares.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_mask;
    logic [31:0] in_pc;
    logic [63:0] in_data;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_inst0, out_pc0, out_inst1, out_pc1;
    logic [1:0]  out_accept;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  v;
        logic [31:0] p0;
        logic [31:0] i0;
        logic [31:0] p1;
        logic [31:0] i1;
        int          cnt;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];

    fetch_queue #(.DEPTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_mask    (in_mask),
        .in_pc      (in_pc),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_inst0  (out_inst0),
        .out_pc0    (out_pc0),
        .out_inst1  (out_inst1),
        .out_pc1    (out_pc1),
        .out_accept (out_accept),
        .count      (count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn === 1'b1 && out_accept == 2'b10) begin
            errors++;
            $display("FAIL accept_legal: out_accept=%b, required never 10", out_accept);
        end
        if (exp_q.size() > 0) begin
            exp_t e;
            logic ok;
            e = exp_q.pop_front();
            checks++;
            ok = (out_valid === e.v) && (int'(count) == e.cnt) && (in_ready === e.rdy);
            if (e.v[0]) ok = ok && (out_pc0 === e.p0) && (out_inst0 === e.i0);
            if (e.v[1]) ok = ok && (out_pc1 === e.p1) && (out_inst1 === e.i1);
            if (!ok) begin
                errors++;
                $display("FAIL %s: got v=%b cnt=%0d rdy=%b pc0=%h i0=%h pc1=%h i1=%h; required v=%b cnt=%0d rdy=%b pc0=%h i0=%h pc1=%h i1=%h",
                         e.name, out_valid, count, in_ready, out_pc0, out_inst0, out_pc1, out_inst1,
                         e.v, e.cnt, e.rdy, e.p0, e.i0, e.p1, e.i1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc,
                         input logic [63:0] d, input logic [1:0] acc, input logic fl);
        in_valid   = v;
        in_mask    = m;
        in_pc      = pc;
        in_data    = d;
        out_accept = acc;
        flush      = fl;
    endtask

    task automatic expect_st(input string name, input logic [1:0] v,
                             input logic [31:0] p0, input logic [31:0] i0,
                             input logic [31:0] p1, input logic [31:0] i1,
                             input int cnt, input logic rdy);
        exp_t e;
        e.name = name; e.v = v; e.p0 = p0; e.i0 = i0; e.p1 = p1; e.i1 = i1;
        e.cnt = cnt; e.rdy = rdy;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 32'h0, 64'h0, 2'b00, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        cyc();
        expect_st("in_reset", 2'b00, 0, 0, 0, 0, 0, 1'b0);
        cyc();
        resetn = 1'b1;
        expect_st("reset_idle", 2'b00, 0, 0, 0, 0, 0, 1'b1);

        // Single push and pop
        drive(1'b1, 2'b11, 32'hBFC00000, {32'h24020002, 32'h24010001}, 2'b00, 1'b0);
        cyc();
        expect_st("push2", 2'b11, 32'hBFC00000, 32'h24010001, 32'hBFC00004, 32'h24020002, 2, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 64'h0, 2'b01, 1'b0);
        cyc();
        expect_st("pop1", 2'b01, 32'hBFC00004, 32'h24020002, 0, 0, 1, 1'b1);
        cyc();
        expect_st("empty", 2'b00, 0, 0, 0, 0, 0, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 64'h0, 2'b11, 1'b0);
        cyc();
        expect_st("empty_accept_ignored", 2'b00, 0, 0, 0, 0, 0, 1'b1);

        // Fill with four 2-slot packets, head sits at index 2
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'b11, 32'h1000 + 32'(8 * k),
                  {32'hA0000000 + 32'(2 * k + 1), 32'hA0000000 + 32'(2 * k)}, 2'b00, 1'b0);
            cyc();
            expect_st($sformatf("fill%0d", k), 2'b11, 32'h1000, 32'hA0000000,
                      32'h1004, 32'hA0000001, 2 * k + 2, (k < 3));
        end
        drive(1'b1, 2'b11, 32'h1020, {32'hA0000009, 32'hA0000008}, 2'b00, 1'b0);
        cyc();
        expect_st("held_off", 2'b11, 32'h1000, 32'hA0000000, 32'h1004, 32'hA0000001, 8, 1'b0);
        // Packet still offered; pop does not admit it in the same cycle
        out_accept = 2'b11;
        cyc();
        expect_st("drain2", 2'b11, 32'h1008, 32'hA0000002, 32'h100C, 32'hA0000003, 6, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 64'h0, 2'b01, 1'b0);
        cyc();
        expect_st("count5", 2'b11, 32'h100C, 32'hA0000003, 32'h1010, 32'hA0000004, 5, 1'b1);

        // Flush with concurrent push and pop
        drive(1'b1, 2'b11, 32'h77777770, {32'h77777771, 32'h77777770}, 2'b11, 1'b1);
        cyc();
        expect_st("flush", 2'b00, 0, 0, 0, 0, 0, 1'b1);
        drive(1'b1, 2'b11, 32'h40000000, {32'hB0000001, 32'hB0000000}, 2'b00, 1'b0);
        cyc();
        expect_st("after_flush", 2'b11, 32'h40000000, 32'hB0000000, 32'h40000004, 32'hB0000001,
                  2, 1'b1);
        drive(1'b1, 2'b11, 32'h40000008, {32'hB0000003, 32'hB0000002}, 2'b11, 1'b0);
        cyc();
        expect_st("stream_a", 2'b11, 32'h40000008, 32'hB0000002, 32'h4000000C, 32'hB0000003,
                  2, 1'b1);
        drive(1'b1, 2'b11, 32'h40000010, {32'hB0000005, 32'hB0000004}, 2'b11, 1'b0);
        cyc();
        expect_st("stream_b", 2'b11, 32'h40000010, 32'hB0000004, 32'h40000014, 32'hB0000005,
                  2, 1'b1);

        // Odd pushes
        drive(1'b1, 2'b01, 32'h8000001C, {32'hDEADBEEF, 32'hC0000000}, 2'b11, 1'b0);
        cyc();
        expect_st("odd_push", 2'b01, 32'h8000001C, 32'hC0000000, 0, 0, 1, 1'b1);
        drive(1'b1, 2'b01, 32'h80000020, {32'hDEADBEEF, 32'hC0000001}, 2'b00, 1'b0);
        cyc();
        expect_st("odd_next", 2'b11, 32'h8000001C, 32'hC0000000, 32'h80000020, 32'hC0000001,
                  2, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 64'h0, 2'b01, 1'b0);
        cyc();
        expect_st("head7", 2'b01, 32'h80000020, 32'hC0000001, 0, 0, 1, 1'b1);

        // Wrap with concurrent push and pop
        drive(1'b1, 2'b11, 32'h80000100, {32'hD0000001, 32'hD0000000}, 2'b01, 1'b0);
        cyc();
        expect_st("wrap_push_pop", 2'b11, 32'h80000100, 32'hD0000000, 32'h80000104, 32'hD0000001,
                  2, 1'b1);

        // 2-slot push straddling 7->0, then a 2-entry view straddling it
        drive(1'b1, 2'b11, 32'h90000000, {32'hF0000001, 32'hF0000000}, 2'b11, 1'b0);
        cyc();
        expect_st("st_a", 2'b11, 32'h90000000, 32'hF0000000, 32'h90000004, 32'hF0000001, 2, 1'b1);
        drive(1'b1, 2'b01, 32'h90000008, {32'h0, 32'hF0000002}, 2'b11, 1'b0);
        cyc();
        expect_st("st_b", 2'b01, 32'h90000008, 32'hF0000002, 0, 0, 1, 1'b1);
        drive(1'b1, 2'b11, 32'h9000000C, {32'hF0000004, 32'hF0000003}, 2'b00, 1'b0);
        cyc();
        expect_st("st_c", 2'b11, 32'h90000008, 32'hF0000002, 32'h9000000C, 32'hF0000003, 3, 1'b1);
        drive(1'b1, 2'b11, 32'h90000100, {32'hF0000006, 32'hF0000005}, 2'b11, 1'b0);
        cyc();
        expect_st("st_d", 2'b11, 32'h90000010, 32'hF0000004, 32'h90000100, 32'hF0000005, 3, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 64'h0, 2'b01, 1'b0);
        cyc();
        expect_st("straddle_view", 2'b11, 32'h90000100, 32'hF0000005, 32'h90000104,
                  32'hF0000006, 2, 1'b1);
        drive(1'b0, 2'b00, 32'h0, 64'h0, 2'b11, 1'b0);
        cyc();
        expect_st("straddle_pop", 2'b00, 0, 0, 0, 0, 0, 1'b1);
        idle();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
